sy_gpio_axil_slave: RTL and testbench

Native AXI4-Lite GPIO responder for the SiYuan SoC. It replaces the vendor GPIO core behind the 64-to-32 bit AXI width converter and serves the 32-bit AXI4-Lite initiator side of the peripheral path. It drives the LED outputs, samples the DIP switches through a synchronizer, and raises a level interrupt on input change. The same RTL therefore runs on Xilinx and non-Xilinx platforms.

---
 rtl/sy_gpio_axil_slave.sv | 187 ++++++++++++++++++
 tb/tb_sy_gpio_axil_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sy_gpio_axil_slave.sv
// AXI4-Lite GPIO responder: LED data register, synchronized switch input,
// and a level interrupt raised on any change of the synchronized switches.
module sy_gpio_axil_slave #(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [8:0]        s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [8:0]        s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [GPIO_W-1:0] leds_o,
    input  logic [GPIO_W-1:0] dip_switches_i,
    output logic              irq_o
);

    typedef enum logic [2:0] {
        REG_DATA, REG_IN, REG_GIER, REG_ISR, REG_IER, REG_NONE
    } reg_sel_t;

    function automatic reg_sel_t decode(input logic [8:0] addr);
        casez (addr)
            9'b0_0000_00??: decode = REG_DATA;
            9'b0_0000_10??: decode = REG_IN;
            9'b1_0001_11??: decode = REG_GIER;
            9'b1_0010_00??: decode = REG_ISR;
            9'b1_0010_10??: decode = REG_IER;
            default:        decode = REG_NONE;
        endcase
    endfunction

    logic              aw_held;
    logic [8:0]        aw_addr_q;
    logic              w_held;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [GPIO_W-1:0] data_q;
    logic              gie_q;
    logic              ier_q;
    logic              isr_q;
    logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_W-1:0] prev_q;
    logic [GPIO_W-1:0] in_sync;

    // A transfer happens on any edge where valid and ready are both high;
    // valid must then hold its payload stable until that edge, and ready
    // never depends combinationally on the matching valid.
    logic aw_hs, w_hs, ar_hs, do_write;
    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;
    assign aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_hs     = s_axi_wvalid && s_axi_wready;
    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign do_write = (aw_held || aw_hs) && (w_held || w_hs);

    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    reg_sel_t    wr_sel;
    assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
    assign wr_data = w_held ? w_data_q : s_axi_wdata;
    assign wr_strb = w_held ? w_strb_q : s_axi_wstrb;
    assign wr_sel  = decode(wr_addr);

    logic [GPIO_W-1:0] data_next;
    always_comb begin
        data_next = data_q;
        for (int i = 0; i < GPIO_W; i++) begin
            if (wr_strb[i/8]) data_next[i] = wr_data[i];
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // A set in the same cycle as a W1C takes priority, so no change is lost.
    logic isr_set, isr_clr;
    assign isr_set = (in_sync != prev_q);
    assign isr_clr = do_write && (wr_sel == REG_ISR) && wr_strb[0] && wr_data[0];

    logic [31:0] rd_data;
    logic        rd_ok;
    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b1;
        case (decode(s_axi_araddr))
            REG_DATA: rd_data[GPIO_W-1:0] = data_q;
            REG_IN:   rd_data[GPIO_W-1:0] = in_sync;
            REG_GIER: rd_data[31] = gie_q;
            REG_ISR:  rd_data[0] = isr_q;
            REG_IER:  rd_data[0] = ier_q;
            default:  rd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= dip_switches_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= in_sync;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            gie_q  <= 1'b0;
            ier_q  <= 1'b0;
            isr_q  <= 1'b0;
        end else begin
            isr_q <= isr_set || (isr_q && !isr_clr);
            if (do_write) begin
                case (wr_sel)
                    REG_DATA: data_q <= data_next;
                    REG_GIER: if (wr_strb[3]) gie_q <= wr_data[31];
                    REG_IER:  if (wr_strb[0]) ier_q <= wr_data[0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_held      <= 1'b0;
            aw_addr_q    <= '0;
            w_held       <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            if (do_write) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= (wr_sel == REG_NONE) ? 2'b10 : 2'b00;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi_wdata;
                    w_strb_q <= s_axi_wstrb;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    assign leds_o = data_q;
    assign irq_o  = gie_q && ier_q && isr_q;

endmodule

// File: tb/tb_sy_gpio_axil_slave.sv
// Directed bench for sy_gpio_axil_slave: register map, write/read channel
// timing, byte strobes, interrupt set/clear priority and mid-transaction reset.
module tb_sy_gpio_axil_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [8:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  leds;
    logic [7:0]  dip = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    sy_gpio_axil_slave #(.GPIO_W(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .leds_o(leds), .dip_switches_i(dip), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_acc, w_acc;
        int   n;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            tick();
            if (aw_acc) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_acc)  begin wvalid = 1'b0;  w_done = 1'b1;  end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [8:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        n = 0;
        araddr = addr; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        data = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  ws;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_leds_in_rst", {24'd0, leds}, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_leds", {24'd0, leds}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_valids", {30'd0, bvalid, rvalid}, 32'h0);
        check("rst_readies", {29'd0, awready, wready, arready}, 32'h7);
        check("rst_resp", {28'd0, bresp, rresp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);

        // Write DATA with AW and W in the same cycle
        awaddr = 9'h000; wdata = 32'h0000_00A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("w1_leds", {24'd0, leds}, 32'hA5);
        check("w1_bvalid", {31'd0, bvalid}, 32'h1);
        check("w1_bresp", {30'd0, bresp}, 32'h0);
        check("w1_awready_busy", {31'd0, awready}, 32'h0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("w1_bvalid_drop", {31'd0, bvalid}, 32'h0);
        axi_read(9'h000, rd, rs);
        check("w1_readback", rd, 32'h0000_00A5);
        check("w1_rresp", {30'd0, rs}, 32'h0);

        // AW first, W three cycles later, bready held low
        awaddr = 9'h000; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("w2_awready_low", {31'd0, awready}, 32'h0);
        check("w2_wready_high", {31'd0, wready}, 32'h1);
        tick();
        tick();
        check("w2_leds_hold", {24'd0, leds}, 32'hA5);
        check("w2_no_bvalid", {31'd0, bvalid}, 32'h0);
        wdata = 32'h0000_003C; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w2_leds", {24'd0, leds}, 32'h3C);
        for (int i = 0; i < 4; i++) begin
            check("w2_b_stable", {29'd0, bvalid, bresp}, 32'h4);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("w2_b_done", {30'd0, bvalid, awready}, 32'h1);

        // Byte strobes, IN writes, unmapped offsets
        axi_write(9'h000, 32'h0000_00FF, 4'h0, ws);
        check("strb0_resp", {30'd0, ws}, 32'h0);
        check("strb0_leds", {24'd0, leds}, 32'h3C);
        axi_write(9'h000, 32'h0000_005A, 4'hE, ws);
        check("strbE_leds", {24'd0, leds}, 32'h3C);
        axi_write(9'h000, 32'hFFFF_FF81, 4'h1, ws);
        check("strb1_leds", {24'd0, leds}, 32'h81);
        axi_write(9'h008, 32'h0000_00FF, 4'hF, ws);
        check("in_write_resp", {30'd0, ws}, 32'h0);
        axi_write(9'h04C, 32'h0000_0000, 4'hF, ws);
        check("bad_write_resp", {30'd0, ws}, 32'h2);
        check("bad_write_leds", {24'd0, leds}, 32'h81);
        axi_read(9'h04C, rd, rs);
        check("bad_read_data", rd, 32'h0);
        check("bad_read_resp", {30'd0, rs}, 32'h2);

        // Interrupt enables; GIER byte 3 gating
        axi_write(9'h11C, 32'h8000_0000, 4'hF, ws);
        axi_write(9'h128, 32'h0000_0001, 4'hF, ws);
        axi_write(9'h11C, 32'h0000_0000, 4'h7, ws);
        axi_read(9'h11C, rd, rs);
        check("gier_strb", rd, 32'h8000_0000);
        axi_read(9'h120, rd, rs);
        check("isr_idle", rd, 32'h0);
        check("irq_idle", {31'd0, irq}, 32'h0);

        // Switch change: visible in IN after 2 edges, irq one edge later
        dip = 8'h3C;
        tick();
        check("sw_irq_e1", {31'd0, irq}, 32'h0);
        tick();
        check("sw_irq_e2", {31'd0, irq}, 32'h0);
        araddr = 9'h008; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("sw_in", rdata, 32'h0000_003C);
        check("sw_irq_e3", {31'd0, irq}, 32'h1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        axi_read(9'h120, rd, rs);
        check("isr_set", rd, 32'h1);
        axi_write(9'h120, 32'h0000_0001, 4'hF, ws);
        check("isr_w1c_irq", {31'd0, irq}, 32'h0);
        axi_write(9'h120, 32'h0000_0001, 4'h0, ws);

        // Set wins over a W1C landing on the same edge
        dip = 8'h00;
        repeat (4) tick();
        check("toggle_irq", {31'd0, irq}, 32'h1);
        dip = 8'hFF;
        tick();
        tick();
        awaddr = 9'h120; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("set_wins_irq", {31'd0, irq}, 32'h1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(9'h120, rd, rs);
        check("set_wins_isr", rd, 32'h1);
        axi_write(9'h120, 32'h0000_0001, 4'h1, ws);
        check("clear_after", {31'd0, irq}, 32'h0);

        // Reset with a read response pending and rready low
        araddr = 9'h000; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("pend_rvalid", {31'd0, rvalid}, 32'h1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", {31'd0, rvalid}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_state", {22'd0, leds, rvalid, arready}, 32'h1);
        check("post_rst_irq", {31'd0, irq}, 32'h0);
        axi_read(9'h000, rd, rs);
        check("post_rst_data", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
